// File: rtl/mcs4_alu_pkg.sv
// mcs4_alu_pkg: shared definitions for the MCS-4 accumulator-group sequencer.
// Holds the accumulator-group opcodes (OPA nibble of 0xF_ instructions), the
// sequencer state type, and the bit map of the ALU strobe word.
package mcs4_alu_pkg;

    localparam int OPC_W = 4;
    localparam int CTL_W = 20;

    // Accumulator-group opcodes
    localparam logic [OPC_W-1:0] OP_CLB = 4'h0;
    localparam logic [OPC_W-1:0] OP_CLC = 4'h1;
    localparam logic [OPC_W-1:0] OP_IAC = 4'h2;
    localparam logic [OPC_W-1:0] OP_CMC = 4'h3;
    localparam logic [OPC_W-1:0] OP_CMA = 4'h4;
    localparam logic [OPC_W-1:0] OP_RAL = 4'h5;
    localparam logic [OPC_W-1:0] OP_RAR = 4'h6;
    localparam logic [OPC_W-1:0] OP_TCC = 4'h7;
    localparam logic [OPC_W-1:0] OP_DAC = 4'h8;
    localparam logic [OPC_W-1:0] OP_TCS = 4'h9;
    localparam logic [OPC_W-1:0] OP_STC = 4'hA;
    localparam logic [OPC_W-1:0] OP_DAA = 4'hB;
    localparam logic [OPC_W-1:0] OP_KBP = 4'hC;
    localparam logic [OPC_W-1:0] OP_DCL = 4'hD;

    // Sequencer states; the two DAA states are only reachable when the
    // decimal-adjust path is built.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        DAA_CHK = 2'd2,
        DAA_ADD = 2'd3
    } seqState_t;

    // ALU strobe bit indices
    localparam int CTL_ACC_ALU  = 0;
    localparam int CTL_ACC_KBP  = 1;
    localparam int CTL_CY_SET   = 2;
    localparam int CTL_CY_INV   = 3;
    localparam int CTL_CY_WRT   = 4;
    localparam int CTL_A_ACC    = 5;
    localparam int CTL_A_RN     = 6;
    localparam int CTL_A_OPROPA = 7;
    localparam int CTL_B_ACC    = 8;
    localparam int CTL_B_RN     = 9;
    localparam int CTL_B_DATA_I = 10;
    localparam int CTL_C_CY     = 11;
    localparam int CTL_C_SET    = 12;
    localparam int CTL_THRU_A   = 13;
    localparam int CTL_THRU_B   = 14;
    localparam int CTL_ADD      = 15;
    localparam int CTL_SUB      = 16;
    localparam int CTL_RAL      = 17;
    localparam int CTL_RAR      = 18;
    localparam int CTL_DAA      = 19;

    // Decimal adjust adds 6 only when the accumulator is out of BCD range
    // or a decimal carry is already pending.
    function automatic logic daaNeeded(input logic [3:0] accVal, input logic cyVal);
        return cyVal || (accVal > 4'd9);
    endfunction

endpackage

// File: rtl/alu_seq_dec.sv
// alu_seq_dec: purely combinational opcode decoder for the accumulator group.
// Maps the latched opcode to the ALU strobe word, the immediate operand and
// the illegal-opcode flag used during the single EXEC cycle.
// Build option: ALU_SEQ_DAA_EN (when absent, opcode 0xB decodes as illegal).
module alu_seq_dec
    import mcs4_alu_pkg::*;
(
    input  logic [OPC_W-1:0] opcode_i,
    output logic [CTL_W-1:0] ctl_o,
    output logic [3:0]       imm_o,
    output logic             ill_o
);

    // Opcode to strobe/immediate table; everything defaults to quiet.
    always_comb begin
        ctl_o = '0;
        imm_o = 4'h0;
        ill_o = 1'b0;
        case (opcode_i)
            OP_CLB: begin
                ctl_o[CTL_THRU_A]   = 1'b1;
                ctl_o[CTL_A_OPROPA] = 1'b1;
                ctl_o[CTL_ACC_ALU]  = 1'b1;
                ctl_o[CTL_CY_WRT]   = 1'b1;
                imm_o               = 4'h0;
            end
            OP_CLC: begin
                ctl_o[CTL_CY_WRT]   = 1'b1;
            end
            OP_IAC: begin
                ctl_o[CTL_A_ACC]    = 1'b1;
                ctl_o[CTL_C_SET]    = 1'b1;
                ctl_o[CTL_ADD]      = 1'b1;
                ctl_o[CTL_ACC_ALU]  = 1'b1;
                ctl_o[CTL_CY_WRT]   = 1'b1;
            end
            OP_CMC: begin
                ctl_o[CTL_CY_INV]   = 1'b1;
            end
            OP_CMA: begin
                ctl_o[CTL_A_OPROPA] = 1'b1;
                ctl_o[CTL_B_ACC]    = 1'b1;
                ctl_o[CTL_C_SET]    = 1'b1;
                ctl_o[CTL_SUB]      = 1'b1;
                ctl_o[CTL_ACC_ALU]  = 1'b1;
                imm_o               = 4'h0;
            end
            OP_RAL: begin
                ctl_o[CTL_A_ACC]    = 1'b1;
                ctl_o[CTL_RAL]      = 1'b1;
                ctl_o[CTL_ACC_ALU]  = 1'b1;
                ctl_o[CTL_CY_WRT]   = 1'b1;
            end
            OP_RAR: begin
                ctl_o[CTL_A_ACC]    = 1'b1;
                ctl_o[CTL_RAR]      = 1'b1;
                ctl_o[CTL_ACC_ALU]  = 1'b1;
                ctl_o[CTL_CY_WRT]   = 1'b1;
            end
            OP_TCC: begin
                ctl_o[CTL_A_OPROPA] = 1'b1;
                ctl_o[CTL_C_CY]     = 1'b1;
                ctl_o[CTL_ADD]      = 1'b1;
                ctl_o[CTL_ACC_ALU]  = 1'b1;
                ctl_o[CTL_CY_WRT]   = 1'b1;
                imm_o               = 4'h0;
            end
            OP_DAC: begin
                ctl_o[CTL_A_OPROPA] = 1'b1;
                ctl_o[CTL_B_ACC]    = 1'b1;
                ctl_o[CTL_ADD]      = 1'b1;
                ctl_o[CTL_ACC_ALU]  = 1'b1;
                ctl_o[CTL_CY_WRT]   = 1'b1;
                imm_o               = 4'hF;
            end
            OP_TCS: begin
                ctl_o[CTL_A_OPROPA] = 1'b1;
                ctl_o[CTL_C_CY]     = 1'b1;
                ctl_o[CTL_ADD]      = 1'b1;
                ctl_o[CTL_ACC_ALU]  = 1'b1;
                ctl_o[CTL_CY_WRT]   = 1'b1;
                imm_o               = 4'h9;
            end
            OP_STC: begin
                ctl_o[CTL_CY_SET]   = 1'b1;
            end
            OP_DAA: begin
`ifdef ALU_SEQ_DAA_EN
                // Handled by the dedicated DAA states; never reaches EXEC.
                ill_o = 1'b0;
`else
                ill_o = 1'b1;
`endif
            end
            OP_KBP: begin
                ctl_o[CTL_ACC_KBP]  = 1'b1;
            end
            OP_DCL: begin
                ill_o = 1'b0;
            end
            default: begin
                ill_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequencer for the MCS-4 accumulator-group instructions. Accepts an
// opcode, latches it and drives the ALU strobes for one cycle (two for a
// decimal adjust that needs the +6 correction), pulsing done on the last one.
// Build option: ALU_SEQ_DAA_EN builds the DAA_CHK/DAA_ADD path; otherwise
// opcode 0xB executes as an illegal opcode.
module alu_seq
    import mcs4_alu_pkg::*;
(
    input  logic             CLK,
    input  logic             RES,
    input  logic             op_valid,
    input  logic [OPC_W-1:0] op_code,
    output logic             op_ready,
    input  logic             stall,
    input  logic [3:0]       acc,
    input  logic             cy,
    input  logic             alu_co,
    output logic [CTL_W-1:0] ctl,
    output logic [3:0]       imm,
    output logic             done,
    output logic             ill
);

    seqState_t        state_q;
    seqState_t        state_d;
    logic [OPC_W-1:0] opcode_q;
    logic [OPC_W-1:0] opcode_d;

    logic [CTL_W-1:0] decCtl;
    logic [3:0]       decImm;
    logic             decIll;

    alu_seq_dec u_dec (
        .opcode_i (opcode_q),
        .ctl_o    (decCtl),
        .imm_o    (decImm),
        .ill_o    (decIll)
    );

`ifndef ALU_SEQ_DAA_EN
    // Without the DAA path the ALU status inputs have no consumer.
    logic unusedDaaInputs;
    assign unusedDaaInputs = ^{acc, cy, alu_co};
`endif

    assign op_ready = ~RES & ~stall & (state_q == IDLE);

    // Next-state and opcode-latch logic; stall freezes the current step.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        if (!stall) begin
            case (state_q)
                IDLE: begin
                    if (op_valid) begin
                        opcode_d = op_code;
`ifdef ALU_SEQ_DAA_EN
                        state_d  = (op_code == OP_DAA) ? DAA_CHK : EXEC;
`else
                        state_d  = EXEC;
`endif
                    end
                end
                EXEC: begin
                    state_d = IDLE;
                end
`ifdef ALU_SEQ_DAA_EN
                DAA_CHK: begin
                    state_d = daaNeeded(acc, cy) ? DAA_ADD : IDLE;
                end
                DAA_ADD: begin
                    state_d = IDLE;
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and latched opcode registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RES) begin
            state_q  <= IDLE;
            opcode_q <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
        end
    end

    // Strobe outputs per state; reset and stall silence everything.
    always_comb begin
        ctl  = '0;
        imm  = 4'h0;
        done = 1'b0;
        ill  = 1'b0;
        if (!RES && !stall) begin
            case (state_q)
                EXEC: begin
                    ctl  = decCtl;
                    imm  = decImm;
                    ill  = decIll;
                    done = 1'b1;
                end
`ifdef ALU_SEQ_DAA_EN
                DAA_CHK: begin
                    done = ~daaNeeded(acc, cy);
                end
                DAA_ADD: begin
                    ctl[CTL_A_ACC]   = 1'b1;
                    ctl[CTL_DAA]     = 1'b1;
                    ctl[CTL_ACC_ALU] = 1'b1;
                    ctl[CTL_CY_SET]  = alu_co;
                    done             = 1'b1;
                end
`endif
                default: begin
                    done = 1'b0;
                end
            endcase
        end
    end

endmodule
